// File: rtl/shared_adder_arbiter.sv
// shared_adder_arbiter: round-robin share of one registered (WIDTH+1)-bit adder; optional SHARED_ADDER_CLEAR_EN adds per-lane clr
module shared_adder_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 2,
    parameter int ID_W    = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] a_in,
    input  logic [NUM_REQ*WIDTH-1:0] b_in,
`ifdef SHARED_ADDER_CLEAR_EN
    input  logic [NUM_REQ-1:0]       clr,
`endif
    output logic [NUM_REQ-1:0]       grant,
    output logic [WIDTH:0]           out,
    output logic                     out_valid,
    output logic [ID_W-1:0]          out_id,
    output logic                     busy
);
    typedef enum logic [1:0] {IDLE, GRANT, RESULT} state_t;
    state_t              r_state;
    logic [ID_W-1:0]     r_rr_ptr;
    logic [ID_W-1:0]     r_id;
    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic                r_clr;
    logic [NUM_REQ-1:0]  r_grant;
    logic [WIDTH:0]      r_out;
    logic                r_out_valid;
    logic [ID_W-1:0]     r_out_id;
    logic [ID_W-1:0]     w_win;
    logic [WIDTH:0]      w_sum;
    logic                w_clr_sel;
    // Round-robin pick: descending scan so the lowest offset from rr_ptr wins
    always_comb begin
        w_win = r_rr_ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (req[(int'(r_rr_ptr) + k) % NUM_REQ]) w_win = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
    end
`ifdef SHARED_ADDER_CLEAR_EN
    assign w_clr_sel = clr[w_win];
`else
    assign w_clr_sel = 1'b0;
`endif
    assign w_sum = r_clr ? '0 : {1'b0, r_a} + {1'b0, r_b};
    // Three-state grant/add/result sequencer with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_id        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_clr       <= 1'b0;
            r_grant     <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_out_id    <= '0;
        end else begin
            case (r_state)
                IDLE: if (|req) begin
                    r_grant <= NUM_REQ'(1) << w_win;
                    r_a     <= a_in[int'(w_win)*WIDTH +: WIDTH];
                    r_b     <= b_in[int'(w_win)*WIDTH +: WIDTH];
                    r_clr   <= w_clr_sel;
                    r_id    <= w_win;
                    r_state <= GRANT;
                end
                GRANT: begin
                    r_grant     <= '0;
                    r_out       <= w_sum;
                    r_out_id    <= r_id;
                    r_out_valid <= 1'b1;
                    r_rr_ptr    <= (r_id == ID_W'(NUM_REQ - 1)) ? '0 : r_id + 1'b1;
                    r_state     <= RESULT;
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end
    assign grant     = r_grant;
    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign out_id    = r_out_id;
    assign busy      = (r_state != IDLE);
endmodule

// File: tb/tb_shared_adder_arbiter.sv
// tb_shared_adder_arbiter: directed table-driven bench for shared_adder_arbiter (SHARED_ADDER_CLEAR_EN sequence when defined)
module tb_shared_adder_arbiter;
    localparam int N = 4;
    localparam int W = 2;
    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] req;
    logic [N-1:0] clr;
    logic [N*W-1:0] a_in;
    logic [N*W-1:0] b_in;
    logic [N-1:0] grant;
    logic [W:0]   out;
    logic         out_valid;
    logic [1:0]   out_id;
    logic         busy;
    int checks = 0;
    int errors = 0;
    shared_adder_arbiter #(.NUM_REQ(N), .WIDTH(W), .ID_W(2)) dut (
        .clk(clk), .reset(reset), .req(req), .a_in(a_in), .b_in(b_in),
`ifdef SHARED_ADDER_CLEAR_EN
        .clr(clr),
`endif
        .grant(grant), .out(out), .out_valid(out_valid), .out_id(out_id), .busy(busy)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic [3:0] req;
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] grant;
        logic [2:0] sum;
        logic [1:0] id;
    } vec_t;
    vec_t vt[6];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset;
        reset = 1'b1;
        req = '0;
        tick;
        reset = 1'b0;
    endtask
    task automatic do_op(input logic [3:0] r, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] eg, input logic [2:0] es, input logic [1:0] ei, input string tag);
        req = r; a_in = a; b_in = b;
        tick;
        chk({tag, " grant"}, 32'(grant), 32'(eg));
        chk({tag, " busy_g"}, 32'(busy), 1);
        chk({tag, " valid_early"}, 32'(out_valid), 0);
        req = '0;
        tick;
        chk({tag, " grant_drop"}, 32'(grant), 0);
        chk({tag, " valid"}, 32'(out_valid), 1);
        chk({tag, " out"}, 32'(out), 32'(es));
        chk({tag, " id"}, 32'(out_id), 32'(ei));
        tick;
        chk({tag, " valid_drop"}, 32'(out_valid), 0);
        chk({tag, " out_hold"}, 32'(out), 32'(es));
        chk({tag, " busy_end"}, 32'(busy), 0);
    endtask
    initial begin
        vt[0] = '{4'b0010, 8'h0C, 8'h08, 4'b0010, 3'd5, 2'd1};
        vt[1] = '{4'b1000, 8'hC0, 8'hC0, 4'b1000, 3'd6, 2'd3};
        vt[2] = '{4'b0001, 8'hFC, 8'hFC, 4'b0001, 3'd0, 2'd0};
        vt[3] = '{4'b0101, 8'h13, 8'h23, 4'b0100, 3'd3, 2'd2};
        vt[4] = '{4'b0011, 8'h0E, 8'h0D, 4'b0001, 3'd3, 2'd0};
        vt[5] = '{4'b1001, 8'h42, 8'hC2, 4'b1000, 3'd4, 2'd3};
        reset = 1'b1; req = '0; a_in = '0; b_in = '0; clr = '0;
        tick;
        tick;
        chk("rst grant", 32'(grant), 0);
        chk("rst out", 32'(out), 0);
        chk("rst valid", 32'(out_valid), 0);
        chk("rst id", 32'(out_id), 0);
        chk("rst busy", 32'(busy), 0);
        reset = 1'b0;
        for (int i = 0; i < 6; i++)
            do_op(vt[i].req, vt[i].a, vt[i].b, vt[i].grant, vt[i].sum, vt[i].id, $sformatf("vec%0d", i));
        // all four requesting, each drops after its own grant
        do_reset;
        req = 4'hF; a_in = {2'd3, 2'd2, 2'd1, 2'd0}; b_in = 8'h55;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk($sformatf("rr%0d grant", i), 32'(grant), 32'(1 << i));
            req[i] = 1'b0;
            tick;
            chk($sformatf("rr%0d valid", i), 32'(out_valid), 1);
            chk($sformatf("rr%0d out", i), 32'(out), 32'(i + 1));
            chk($sformatf("rr%0d id", i), 32'(out_id), 32'(i));
            tick;
            chk($sformatf("rr%0d valid_drop", i), 32'(out_valid), 0);
        end
        // reset during GRANT discards result and restarts rr_ptr at 0
        do_op(4'b0100, 8'h10, 8'h10, 4'b0100, 3'd2, 2'd2, "pre_rst");
        req = 4'b0010; a_in = '0; b_in = '0;
        tick;
        chk("mid grant", 32'(grant), 32'(4'b0010));
        reset = 1'b1; req = '0;
        tick;
        chk("mid grant0", 32'(grant), 0);
        chk("mid out0", 32'(out), 0);
        chk("mid valid0", 32'(out_valid), 0);
        chk("mid id0", 32'(out_id), 0);
        chk("mid busy0", 32'(busy), 0);
        reset = 1'b0;
        tick;
        chk("mid no_valid", 32'(out_valid), 0);
        do_op(4'b1001, 8'h01, 8'h02, 4'b0001, 3'd3, 2'd0, "rr_restart");
        do_op(4'b1000, 8'hC0, 8'h40, 4'b1000, 3'd4, 2'd3, "post_rst");
        // operands changed after the grant edge must not matter
        req = 4'b0100; a_in = 8'h10; b_in = 8'h20;
        tick;
        chk("latch grant", 32'(grant), 32'(4'b0100));
        req = '0; a_in = 8'hFF; b_in = 8'hFF;
        tick;
        chk("latch valid", 32'(out_valid), 1);
        chk("latch out", 32'(out), 3);
        chk("latch id", 32'(out_id), 2);
        tick;
`ifdef SHARED_ADDER_CLEAR_EN
        clr = 4'b0100;
        do_op(4'b0100, 8'h10, 8'h10, 4'b0100, 3'd0, 2'd2, "clr");
        clr = '0;
        do_op(4'b0100, 8'h10, 8'h10, 4'b0100, 3'd2, 2'd2, "noclr");
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
